// File: rtl/bp_fpga_host_tx_arb.sv
`default_nettype none
// ============================================================================
// Module  : bp_fpga_host_tx_arb
// Brief   : Packet-atomic round-robin arbiter that serializes NBF packets,
//           least-significant byte first, onto the UART transmit byte link.
// Revision: 1.0
// ============================================================================
module bp_fpga_host_tx_arb #(
  parameter int nbf_width_p      = 112,
  parameter int uart_data_bits_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [nbf_width_p-1:0]      nbf0_i,
  input  logic                        nbf0_v_i,
  output logic                        nbf0_yumi_o,

  input  logic [nbf_width_p-1:0]      nbf1_i,
  input  logic                        nbf1_v_i,
  output logic                        nbf1_yumi_o,

  output logic [uart_data_bits_p-1:0] tx_data_o,
  output logic                        tx_v_o,
  input  logic                        tx_yumi_i,

  output logic                        busy_o,
  output logic                        grant_o,
  output logic                        pkt_done_o
);

  localparam int nbf_bytes_lp = nbf_width_p / uart_data_bits_p;
  localparam int cnt_w_lp     = (nbf_bytes_lp > 1) ? $clog2(nbf_bytes_lp) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(nbf_bytes_lp - 1);

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_send = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [nbf_width_p-1:0] shift_q, shift_d;
  logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic                   done_q, done_d;

  logic any_v;
  logic both_v;
  logic winner;
  logic take;

  always_comb begin
    any_v  = nbf0_v_i | nbf1_v_i;
    both_v = nbf0_v_i & nbf1_v_i;
    // A lone requester always wins; on contention the last winner yields.
    winner = both_v ? ~last_grant_q : nbf1_v_i;
    take   = (state_q == e_idle) & any_v & ~reset_i;

    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    done_d       = 1'b0;

    case (state_q)
      e_idle: begin
        if (any_v) begin
          state_d      = e_send;
          shift_d      = winner ? nbf1_i : nbf0_i;
          cnt_d        = cnt_last_lp;
          grant_d      = winner;
          last_grant_d = winner;
        end
      end
      e_send: begin
        if (tx_yumi_i) begin
          if (cnt_q == '0) begin
            state_d = e_idle;
            done_d  = 1'b1;
          end else begin
            shift_d = shift_q >> uart_data_bits_p;
            cnt_d   = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_idle;
      shift_q      <= '0;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      done_q       <= done_d;
    end
  end

  assign nbf0_yumi_o = take & ~winner;
  assign nbf1_yumi_o = take & winner;
  assign tx_v_o      = (state_q == e_send);
  assign busy_o      = (state_q == e_send);
  assign tx_data_o   = shift_q[uart_data_bits_p-1:0];
  assign grant_o     = grant_q;
  assign pkt_done_o  = done_q;

  // The transmitter may only accept a byte that is being offered.
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    tx_yumi_i |-> tx_v_o);

endmodule
`default_nettype wire

// File: tb/tb_bp_fpga_host_tx_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_bp_fpga_host_tx_arb
// Brief   : Directed, self-checking bench for the NBF-to-UART transmit arbiter.
// Revision: 1.0
// ============================================================================
module tb_bp_fpga_host_tx_arb;

  localparam int NBF_W = 112;
  localparam int NB    = NBF_W / 8;

  logic             clk_i;
  logic             reset_i;
  logic [NBF_W-1:0] nbf0_i, nbf1_i;
  logic             nbf0_v_i, nbf1_v_i;
  logic             nbf0_yumi_o, nbf1_yumi_o;
  logic [7:0]       tx_data_o;
  logic             tx_v_o, tx_yumi_i;
  logic             busy_o, grant_o, pkt_done_o;

  bp_fpga_host_tx_arb #(.nbf_width_p(NBF_W), .uart_data_bits_p(8)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .nbf0_i      (nbf0_i),
    .nbf0_v_i    (nbf0_v_i),
    .nbf0_yumi_o (nbf0_yumi_o),
    .nbf1_i      (nbf1_i),
    .nbf1_v_i    (nbf1_v_i),
    .nbf1_yumi_o (nbf1_yumi_o),
    .tx_data_o   (tx_data_o),
    .tx_v_o      (tx_v_o),
    .tx_yumi_i   (tx_yumi_i),
    .busy_o      (busy_o),
    .grant_o     (grant_o),
    .pkt_done_o  (pkt_done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stimulus knobs owned by the main sequence; the driver turns them into pins.
  int   src0_left = 0, src1_left = 0;
  int   bp_period = 1;
  int   cyc_cnt   = 0;
  logic y0_seen = 1'b0, y1_seen = 1'b0;

  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (y0_seen && src0_left > 0) src0_left--;
      if (y1_seen && src1_left > 0) src1_left--;
      nbf0_v_i  = (src0_left > 0);
      nbf1_v_i  = (src1_left > 0);
      cyc_cnt++;
      tx_yumi_i = tx_v_o && ((cyc_cnt % bp_period) == 0);
    end
  end

  // Reference model: a packet in flight is just a queue of bytes still owed.
  logic [7:0]       m_q[$];
  logic             m_last  = 1'b1;
  logic             m_grant = 1'b0;
  logic             m_done  = 1'b0;
  logic [7:0]       acc_q[$];
  int               glog[$];
  int               busy_cnt = 0, done_cnt = 0;
  logic             e_busy, e_y0, e_y1, w;
  logic [NBF_W-1:0] pkt;

  always @(negedge clk_i) begin
    e_busy = (m_q.size() != 0);
    w      = (nbf0_v_i && nbf1_v_i) ? !m_last : nbf1_v_i;
    e_y0   = !reset_i && !e_busy && (nbf0_v_i || nbf1_v_i) && !w;
    e_y1   = !reset_i && !e_busy && (nbf0_v_i || nbf1_v_i) && w;

    chk("tx_v", 32'(tx_v_o), 32'(e_busy));
    chk("busy", 32'(busy_o), 32'(e_busy));
    if (e_busy) begin
      chk("tx_data", 32'(tx_data_o), 32'(m_q[0]));
      chk("grant", 32'(grant_o), 32'(m_grant));
    end
    chk("yumi0", 32'(nbf0_yumi_o), 32'(e_y0));
    chk("yumi1", 32'(nbf1_yumi_o), 32'(e_y1));
    chk("pkt_done", 32'(pkt_done_o), 32'(m_done));

    y0_seen = nbf0_yumi_o;
    y1_seen = nbf1_yumi_o;
    if (!reset_i) begin
      if (tx_v_o && tx_yumi_i) acc_q.push_back(tx_data_o);
      if (nbf0_yumi_o) glog.push_back(0);
      if (nbf1_yumi_o) glog.push_back(1);
      if (busy_o) busy_cnt++;
      if (pkt_done_o) done_cnt++;
    end

    if (reset_i) begin
      m_q.delete();
      m_last  = 1'b1;
      m_grant = 1'b0;
      m_done  = 1'b0;
    end else begin
      m_done = e_busy && tx_yumi_i && (m_q.size() == 1);
      if (e_busy) begin
        if (tx_yumi_i) void'(m_q.pop_front());
      end else if (nbf0_v_i || nbf1_v_i) begin
        pkt = w ? nbf1_i : nbf0_i;
        for (int i = 0; i < NB; i++) m_q.push_back(pkt[8*i +: 8]);
        m_grant = w;
        m_last  = w;
      end
    end
  end

  task automatic step();
    @(posedge clk_i); #2;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    glog.delete();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    step();
    while ((src0_left != 0 || src1_left != 0 || busy_o || nbf0_v_i || nbf1_v_i) && n < budget) begin
      step();
      n++;
    end
    repeat (2) step();
    chk("timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    reset_i = 1'b1;
    repeat (cycles) step();
    reset_i = 1'b0;
  endtask

  int n0, n1;

  initial begin
    reset_i   = 1'b1;
    nbf0_i    = '0;
    nbf1_i    = '0;
    nbf0_v_i  = 1'b0;
    nbf1_v_i  = 1'b0;
    tx_yumi_i = 1'b0;
    repeat (3) step();
    chk("rst_tx_v", 32'(tx_v_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_done", 32'(pkt_done_o), 32'd0);
    chk("rst_yumi", 32'({nbf0_yumi_o, nbf1_yumi_o}), 32'd0);
    reset_i = 1'b0;
    step();

    // Single packet, byte i carries value i+1.
    clear_logs();
    bp_period = 1;
    nbf0_i    = 112'h0E0D0C0B0A090807060504030201;
    src0_left = 1;
    wait_quiet(200);
    chk("t1_len", 32'(acc_q.size()), 32'd14);
    for (int i = 0; i < NB; i++) chk("t1_byte", 32'(acc_q[i]), 32'(i + 1));
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd14);
    chk("t1_done_pulses", 32'(done_cnt), 32'd1);
    chk("t1_grants", 32'(glog.size()), 32'd1);

    // Simultaneous request straight after reset: source 0 first.
    do_reset(1);
    clear_logs();
    nbf0_i    = {NB{8'hAA}};
    nbf1_i    = {NB{8'h55}};
    src0_left = 1;
    src1_left = 1;
    wait_quiet(200);
    chk("t2_ngrant", 32'(glog.size()), 32'd2);
    chk("t2_grant0", 32'(glog[0]), 32'd0);
    chk("t2_grant1", 32'(glog[1]), 32'd1);
    chk("t2_len", 32'(acc_q.size()), 32'd28);
    chk("t2_first", 32'(acc_q[0]), 32'hAA);
    chk("t2_b13", 32'(acc_q[13]), 32'hAA);
    chk("t2_b14", 32'(acc_q[14]), 32'h55);
    chk("t2_last", 32'(acc_q[27]), 32'h55);
    chk("t2_done_pulses", 32'(done_cnt), 32'd2);

    // Continuous contention over four packets.
    clear_logs();
    src0_left = 2;
    src1_left = 2;
    wait_quiet(300);
    chk("t3_ngrant", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_order", 32'(glog[i]), 32'(i % 2));
    n0 = 0;
    n1 = 0;
    foreach (glog[i]) if (glog[i] == 0) n0++; else n1++;
    chk("t3_yumi0_cnt", 32'(n0), 32'd2);
    chk("t3_yumi1_cnt", 32'(n1), 32'd2);

    // Backpressure: transmitter accepts on every 10th cycle only.
    clear_logs();
    bp_period = 10;
    nbf0_i    = 112'h1D1C1B1A191817161514131211_10;
    src0_left = 1;
    wait_quiet(400);
    chk("t4_len", 32'(acc_q.size()), 32'd14);
    for (int i = 0; i < NB; i++) chk("t4_byte", 32'(acc_q[i]), 32'(8'h10 + 8'(i)));
    chk("t4_done_pulses", 32'(done_cnt), 32'd1);

    // Reset in the middle of a packet.
    clear_logs();
    bp_period = 1;
    nbf1_i    = 112'h2D2C2B2A292827262524232221_20;
    src1_left = 1;
    begin
      int n = 0;
      while (acc_q.size() < 6 && n < 100) begin
        step();
        n++;
      end
      chk("t5_timeout", 32'(n < 100), 32'd1);
    end
    reset_i = 1'b1;
    step();
    chk("t5_tx_v_after_rst", 32'(tx_v_o), 32'd0);
    chk("t5_busy_after_rst", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    step();
    clear_logs();
    nbf1_i    = 112'h3D3C3B3A393837363534333231_30;
    src1_left = 1;
    wait_quiet(200);
    chk("t5_len", 32'(acc_q.size()), 32'd14);
    chk("t5_first", 32'(acc_q[0]), 32'h30);
    chk("t5_last", 32'(acc_q[13]), 32'h3D);
    chk("t5_grant", 32'(glog[0]), 32'd1);

    // Lone requester repeating: last grant never blocks it.
    clear_logs();
    nbf1_i    = {NB{8'hC3}};
    src1_left = 3;
    wait_quiet(300);
    chk("t6_ngrant", 32'(glog.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t6_grant", 32'(glog[i]), 32'd1);
    chk("t6_len", 32'(acc_q.size()), 32'd42);
    chk("t6_busy_cycles", 32'(busy_cnt), 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
